// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory-wait freeze with timeout to HALT.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters; otherwise they read as zero.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             stall_out,
    output logic             flush_out,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        UNUSED   = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic mem_stall;
    logic apply_run;

    always_comb begin
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        mem_stall = mem_req && !mem_ready;
    end

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_write  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        stall_out     = 1'b0;
        flush_out     = 1'b0;
        apply_run     = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            // Timed out: everything stays frozen until reset; mem_timeout is the status.
            HALT: begin
                state_d = HALT;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    apply_run = 1'b1;
                    state_d   = RUN;
                end else begin
                    stall_out = 1'b1;
                    if (wait_cnt_q == TIMEOUT_L - 8'd1) begin
                        state_d = HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                if (mem_stall) begin
                    stall_out  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    apply_run = 1'b1;
                end
            end
        endcase

        if (apply_run) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            // A taken branch kills the dependent instruction anyway, so it overrides the bubble.
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_out   = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall_out   = 1'b1;
            end
        end

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            stall_out    = 1'b0;
            flush_out    = 1'b0;
        end

        mem_timeout_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_out);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_out);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a rule-level model checked every cycle plus directed literal checks.
module tb_pipeline_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, if_id_write, ex_mem_write, mem_wb_write;
    logic          if_id_flush, id_ex_flush, stall_out, flush_out, mem_timeout;
    logic [1:0]    state;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_out(stall_out), .flush_out(flush_out), .mem_timeout(mem_timeout),
        .state(state),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 running, 1 waiting on memory, 2 halted; counts are plain integers.
    int m_mode, m_waited, m_stalls, m_flushes;
    logic m_hazard, m_live, m_mem_hold;
    logic e_pc, e_ifid, e_exmem, e_memwb, e_ififl, e_idexfl, e_stall, e_flush;

    assign m_hazard   = ex_mem_read && (ex_rd != 5'd0) &&
                        (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    assign m_live     = reset && ((m_mode == 0 && !(mem_req && !mem_ready)) ||
                                  (m_mode == 1 && mem_ready));
    assign m_mem_hold = reset && ((m_mode == 0 && mem_req && !mem_ready) ||
                                  (m_mode == 1 && !mem_ready));

    always @* begin
        e_flush  = m_live && ex_branch_taken;
        e_stall  = m_mem_hold || (m_live && !ex_branch_taken && m_hazard);
        e_pc     = m_live && !(m_hazard && !ex_branch_taken);
        e_ifid   = e_pc;
        e_exmem  = m_live;
        e_memwb  = m_live;
        e_ififl  = e_flush;
        e_idexfl = e_flush || (m_live && m_hazard);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode    <= 0;
            m_waited  <= 0;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            if (e_stall) m_stalls  <= (m_stalls + 1) % (1 << CW);
            if (e_flush) m_flushes <= (m_flushes + 1) % (1 << CW);
            if (m_mode == 0 && mem_req && !mem_ready) begin
                m_mode   <= 1;
                m_waited <= 0;
            end else if (m_mode == 1) begin
                if (mem_ready) m_mode <= 0;
                else if (m_waited + 1 >= TO) m_mode <= 2;
                else m_waited <= m_waited + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("pc_write",     32'(pc_write),     32'(e_pc));
        check("if_id_write",  32'(if_id_write),  32'(e_ifid));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e_exmem));
        check("mem_wb_write", 32'(mem_wb_write), 32'(e_memwb));
        check("if_id_flush",  32'(if_id_flush),  32'(e_ififl));
        check("id_ex_flush",  32'(id_ex_flush),  32'(e_idexfl));
        check("stall_out",    32'(stall_out),    32'(e_stall));
        check("flush_out",    32'(flush_out),    32'(e_flush));
        check("state",        32'(state),        32'(m_mode));
        check("mem_timeout",  32'(mem_timeout),  32'(m_mode == 2));
        check("perf_stall",   32'(perf_stall_cnt), PERF ? 32'(m_stalls)  : 32'd0);
        check("perf_flush",   32'(perf_flush_cnt), PERF ? 32'(m_flushes) : 32'd0);
    end

    // One cycle of stimulus; returns just after the falling edge so outputs can be checked.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic rq, input logic rdy);
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
        mem_req = rq; mem_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_pc_write", 32'(pc_write), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        idle();
        check("run_pc_write", 32'(pc_write), 32'd1);
        check("run_ex_mem_write", 32'(ex_mem_write), 32'd1);

        // load-use on rs1
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_if_id_write", 32'(if_id_write), 32'd0);
        check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("lu_stall_out", 32'(stall_out), 32'd1);
        idle();
        check("lu_after_pc_write", 32'(pc_write), 32'd1);
        check("lu_after_stall", 32'(stall_out), 32'd0);

        // x0 never hazards; rs2 only when used
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_stall", 32'(stall_out), 32'd0);
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        check("rs2_unused_stall", 32'(stall_out), 32'd0);
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        check("rs2_used_stall", 32'(stall_out), 32'd1);

        // branch wins over load-use
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("br_flush_out", 32'(flush_out), 32'd1);
        check("br_if_id_flush", 32'(if_id_flush), 32'd1);
        check("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
        check("br_stall_out", 32'(stall_out), 32'd0);
        check("br_pc_write", 32'(pc_write), 32'd1);

        // request completing in the same cycle needs no wait
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("memhit_stall", 32'(stall_out), 32'd0);
        idle();
        check("memhit_state", 32'(state), 32'd0);

        // three-cycle memory wait with a held branch, resolved on ready
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("mw0_state", 32'(state), 32'd0);
        check("mw0_pc_write", 32'(pc_write), 32'd0);
        check("mw0_flush_out", 32'(flush_out), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("mw1_state", 32'(state), 32'd1);
        check("mw1_mem_wb_write", 32'(mem_wb_write), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("mw2_state", 32'(state), 32'd1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("mw_ready_flush_out", 32'(flush_out), 32'd1);
        check("mw_ready_pc_write", 32'(pc_write), 32'd1);
        idle();
        check("mw_back_state", 32'(state), 32'd0);
        check("mw_stall_cnt", 32'(perf_stall_cnt), PERF ? 32'd3 : 32'd0);
        check("mw_flush_cnt", 32'(perf_flush_cnt), PERF ? 32'd1 : 32'd0);

        // 17 flushes wrap a 4-bit counter to 1
        do_reset();
        repeat (17) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle();
        check("wrap_flush_cnt", 32'(perf_flush_cnt), PERF ? 32'd1 : 32'd0);

        // timeout into HALT, then asynchronous reset out of it
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("to_run_state", 32'(state), 32'd0);
        repeat (4) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("to_last_wait_state", 32'(state), 32'd1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("to_halt_state", 32'(state), 32'd2);
        check("to_mem_timeout", 32'(mem_timeout), 32'd1);
        check("to_halt_pc_write", 32'(pc_write), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("halt_ready_state", 32'(state), 32'd2);
        check("halt_ready_ex_mem_write", 32'(ex_mem_write), 32'd0);
        check("halt_ready_flush_out", 32'(flush_out), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_mem_timeout", 32'(mem_timeout), 32'd0);
        check("async_rst_pc_write", 32'(pc_write), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_pc_write", 32'(pc_write), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles in MEM_WAIT before HALT (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of performance counters.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rs2  in  1  ID instruction reads rs2.
REQ-007 SHALL have ports ex_mem_read  in  1 and ex_rd  in  5  meaning EX holds a load with destination ex_rd.
REQ-008 SHALL have port ex_branch_taken  in  1  meaning branch resolved taken in EX.
REQ-009 SHALL have ports mem_req  in  1 and mem_ready  in  1  meaning MEM-stage data access request and completion.
REQ-010 SHALL have ports pc_write, if_id_write, ex_mem_write, mem_wb_write  out  1 each  meaning pipeline register enables.
REQ-011 SHALL have ports if_id_flush, id_ex_flush  out  1 each  meaning insert bubble into that register.
REQ-012 SHALL have ports stall_out, flush_out, mem_timeout  out  1 each  meaning status.
REQ-013 SHALL have port state  out  2  meaning current FSM state.
REQ-014 SHALL have ports perf_stall_cnt, perf_flush_cnt  out  CNT_W each  meaning event counters.

Function
REQ-015 SHALL implement FSM states RUN=0, MEM_WAIT=1, HALT=2; encoding 3 unused and SHALL return to RUN.
REQ-016 SHALL detect load-use (RUN) when ex_mem_read, ex_rd!=0, and ex_rd==id_rs1 or (id_uses_rs2 and ex_rd==id_rs2).
REQ-017 SHALL, on load-use in RUN, drive pc_write=0, if_id_write=0, id_ex_flush=1, stall_out=1 in the same cycle (one-bubble stall, combinational).
REQ-018 SHALL, on ex_branch_taken in RUN, drive if_id_flush=1, id_ex_flush=1, flush_out=1, pc_write=1 in the same cycle.
REQ-019 SHALL give branch flush priority over load-use; no stall_out when both occur.
REQ-020 SHALL, in RUN with mem_req=1 and mem_ready=0, enter MEM_WAIT next edge; mem_req with mem_ready in the same cycle completes with no wait.
REQ-021 SHALL, whenever mem_req=1 and mem_ready=0 (RUN or MEM_WAIT), freeze all stages: pc_write, if_id_write, ex_mem_write, mem_wb_write=0, no flushes, stall_out=1.
REQ-022 SHALL, in MEM_WAIT, count wait cycles; on mem_ready=1 apply normal RUN rules that cycle (incl. a held ex_branch_taken) and return to RUN.
REQ-023 SHALL enter HALT when the wait counter reaches TIMEOUT without mem_ready; HALT freezes all enables, asserts mem_timeout=1, exits only by reset.
REQ-024 SHALL clear the wait counter on every entry to MEM_WAIT.
REQ-025 SHALL treat register 0 as never hazarding.
REQ-026 SHALL otherwise drive all write enables 1, flushes 0, stall_out/flush_out 0.

Reset
REQ-027 SHALL, while reset=0, hold state=RUN, wait counter 0, counters 0, mem_timeout=0, all enables and flushes 0, stall_out=0, flush_out=0.
REQ-028 SHALL abort MEM_WAIT or HALT immediately on reset assertion, asynchronously, regardless of mem_ready.
REQ-029 SHALL resume RUN behaviour at the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with PIPE_CTRL_PERF_EN defined, increment perf_stall_cnt on each cycle stall_out=1 and perf_flush_cnt on each cycle flush_out=1, wrapping modulo 2^CNT_W.
REQ-031 SHALL, without PIPE_CTRL_PERF_EN, tie both counters to 0 and contain no counter flops.

Verification
REQ-032 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle pc_write=0, id_ex_flush=1, stall_out=1; next cycle normal.
REQ-033 SHALL cover x0/rs2 filter: ex_rd=0 matching id_rs1=0 -> no stall; ex_rd=7=id_rs2 with id_uses_rs2=0 -> no stall.
REQ-034 SHALL cover branch+load-use same cycle: ex_branch_taken=1 and hazard -> flush_out=1, if_id_flush=id_ex_flush=1, stall_out=0.
REQ-035 SHALL cover memory wait: mem_req=1, mem_ready low 3 cycles -> state=1, all enables 0 for 3 cycles, RUN after ready; perf_stall_cnt=3 when PIPE_CTRL_PERF_EN.
REQ-036 SHALL cover timeout: TIMEOUT=4, mem_ready held 0 -> state=2, mem_timeout=1, frozen; reset=0 mid-HALT -> state=0, mem_timeout=0 without clock edge.
REQ-037 SHALL cover counter wrap: CNT_W=4, 17 flush cycles -> perf_flush_cnt=1.
